// File: rtl/cart_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cart_responder
// Description : Game Boy cartridge-bus responder. Synchronises the
//               asynchronous cartridge bus into clk_8m, serves claimed reads
//               through a local request/valid memory port, and turns claimed
//               write strobes into an {address, data} event stream.
//               Macro CART_RESPONDER_WFIFO_EN selects a WFIFO_DEPTH-entry
//               first-word-fall-through write FIFO; without it a single
//               holding register buffers write events.
// Revision    : 1.0 - initial release
// ============================================================================
module cart_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic        clk_8m,
    input  logic        rst,
    input  logic [15:0] gb_a,
    input  logic [7:0]  gb_d_in,
    input  logic        gb_nrd,
    input  logic        gb_nwr,
    input  logic        gb_ncs,
    output logic [7:0]  gb_d_out,
    output logic        gb_d_oe,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        overflow
);

    // Synchroniser word: {valid, nrd, nwr, ncs, data[7:0], addr[15:0]}.
    // The valid bit marks stages that hold a real pin sample rather than
    // the reset image, so no write edge is inferred from reset values.
    localparam logic [27:0] c_SYNC_IDLE = {1'b0, 3'b111, 8'h00, 16'h0000};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRIVE = 2'd3
    } state_t;

    logic [27:0] r_sync [SYNC_STAGES];
    logic [27:0] w_sync;
    logic        w_s_vld;
    logic        w_s_nrd;
    logic        w_s_nwr;
    logic        w_s_ncs;
    logic [7:0]  w_s_d;
    logic [15:0] w_s_a;
    logic        w_claimed;
    logic        r_nwr_prev;
    logic        r_prev_vld;
    logic        w_wr_event;
    state_t      r_state;

    // Multi-stage synchronisers on every asynchronous cartridge input
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= c_SYNC_IDLE;
            end
        end else begin
            r_sync[0] <= {1'b1, gb_nrd, gb_nwr, gb_ncs, gb_d_in, gb_a};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_s_vld = w_sync[27];
    assign w_s_nrd = w_sync[26];
    assign w_s_nwr = w_sync[25];
    assign w_s_ncs = w_sync[24];
    assign w_s_d   = w_sync[23:16];
    assign w_s_a   = w_sync[15:0];

    // ROM window is the lower half; external RAM is 0xA000-0xBFFF with /CS low
    assign w_claimed = ~w_s_a[15] | (~w_s_ncs & (w_s_a[15:13] == 3'b101));

    // Previous write strobe level, used to find falling edges of s_nwr
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            r_nwr_prev <= 1'b1;
            r_prev_vld <= 1'b0;
        end else begin
            r_nwr_prev <= w_s_nwr;
            r_prev_vld <= w_s_vld;
        end
    end

    // Both samples of the edge must come from the pin, not from reset values
    assign w_wr_event = w_s_vld & r_prev_vld & r_nwr_prev & ~w_s_nwr & w_claimed;

    // Read state machine: fetch from local memory, then drive the bus
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            gb_d_oe  <= 1'b0;
            gb_d_out <= 8'h00;
            mem_rd   <= 1'b0;
            mem_addr <= 16'h0000;
        end else begin
            mem_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_s_nrd && w_claimed) begin
                        r_state  <= ST_FETCH;
                        mem_addr <= w_s_a;
                        mem_rd   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // mem_valid in this cycle is deliberately not looked at
                    r_state <= w_s_nrd ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_s_nrd) begin
                        r_state <= ST_IDLE;
                    end else if (mem_valid) begin
                        r_state  <= ST_DRIVE;
                        gb_d_out <= mem_data;
                        gb_d_oe  <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (w_s_nrd) begin
                        r_state <= ST_IDLE;
                        gb_d_oe <= 1'b0;
                    end else if (w_s_a != mem_addr) begin
                        gb_d_oe <= 1'b0;
                        if (w_claimed) begin
                            r_state  <= ST_FETCH;
                            mem_addr <= w_s_a;
                            mem_rd   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    gb_d_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef CART_RESPONDER_WFIFO_EN
    localparam int c_AW = $clog2(WFIFO_DEPTH);

    logic [23:0]   r_fifo_mem [WFIFO_DEPTH];
    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;
    logic [23:0]   w_head;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_pop   = ~w_empty & wr_ready;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign w_push  = w_wr_event & (~w_full | w_pop);
    assign w_head  = r_fifo_mem[r_rptr[c_AW-1:0]];

    assign wr_valid = ~w_empty;
    assign wr_addr  = w_empty ? 16'h0000 : w_head[23:8];
    assign wr_data  = w_empty ? 8'h00    : w_head[7:0];

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk_8m) begin
        if (w_push) begin
            r_fifo_mem[r_wptr[c_AW-1:0]] <= {w_s_a, w_s_d};
        end
    end

    // FIFO pointers and sticky overflow
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (c_AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (c_AW+1)'(1);
            end
            if (w_wr_event && w_full && !w_pop) begin
                overflow <= 1'b1;
            end
        end
    end
`else
    logic        r_hold_vld;
    logic [15:0] r_hold_addr;
    logic [7:0]  r_hold_data;

    assign wr_valid = r_hold_vld;
    assign wr_addr  = r_hold_addr;
    assign wr_data  = r_hold_data;

    // Single-entry holding register; a same-cycle pop frees it for the new event
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            r_hold_vld  <= 1'b0;
            r_hold_addr <= 16'h0000;
            r_hold_data <= 8'h00;
            overflow    <= 1'b0;
        end else begin
            if (w_wr_event && (!r_hold_vld || wr_ready)) begin
                r_hold_vld  <= 1'b1;
                r_hold_addr <= w_s_a;
                r_hold_data <= w_s_d;
            end else if (r_hold_vld && wr_ready) begin
                r_hold_vld <= 1'b0;
            end
            if (w_wr_event && r_hold_vld && !wr_ready) begin
                overflow <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cart_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cart_responder
// Description : Self-checking bench for cart_responder: table-driven reads,
//               directed corner sequences and randomized reads/writes against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_responder;

    localparam int SYNC = 2;
`ifdef CART_RESPONDER_WFIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk_8m;
    logic        rst;
    logic [15:0] gb_a;
    logic [7:0]  gb_d_in;
    logic        gb_nrd;
    logic        gb_nwr;
    logic        gb_ncs;
    logic [7:0]  gb_d_out;
    logic        gb_d_oe;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        overflow;

    cart_responder #(.SYNC_STAGES(SYNC), .WFIFO_DEPTH(4)) dut (
        .clk_8m   (clk_8m),
        .rst      (rst),
        .gb_a     (gb_a),
        .gb_d_in  (gb_d_in),
        .gb_nrd   (gb_nrd),
        .gb_nwr   (gb_nwr),
        .gb_ncs   (gb_ncs),
        .gb_d_out (gb_d_out),
        .gb_d_oe  (gb_d_oe),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .mem_valid(mem_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .overflow (overflow)
    );

    initial clk_8m = 1'b0;
    always #5 clk_8m = ~clk_8m;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 2;
    int          rd_pulses = 0;
    logic [15:0] last_rd_addr = 16'h0000;
    logic [23:0] q[$];
    logic        model_ovf;

    typedef struct {
        logic [15:0] addr;
        logic        ncs;
        logic        claim;
    } read_vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_8m);
        #1;
    endtask

    // Contents of the local memory seen through the read port
    function automatic logic [7:0] rom(input logic [15:0] a);
        logic [7:0] hi;
        hi = a[15:8];
        if (a == 16'h0150) return 8'h3E;
        return a[7:0] ^ (hi << 1) ^ 8'h5C;
    endfunction

    function automatic logic is_claimed(input logic [15:0] a, input logic ncs);
        return !a[15] || (!ncs && a[15:13] == 3'b101);
    endfunction

    // Local memory: answers each mem_rd after 'lat' cycles (0 = same cycle)
    initial begin : responder
        logic [15:0] ra;
        int          l;
        mem_valid = 1'b0;
        mem_data  = 8'h00;
        @(posedge clk_8m);
        #1;
        forever begin
            if (mem_rd) begin
                ra = mem_addr;
                l  = lat;
                repeat (l) step();
                mem_valid = 1'b1;
                mem_data  = rom(ra);
                step();
                mem_valid = 1'b0;
            end else begin
                step();
            end
        end
    end

    // Count read requests and remember their address
    initial begin : rd_monitor
        forever begin
            @(negedge clk_8m);
            if (mem_rd) begin
                rd_pulses++;
                last_rd_addr = mem_addr;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic wait_oe(input logic lvl, input int bound, output int steps, output logic ok);
        ok    = 1'b0;
        steps = 0;
        while (steps < bound && !ok) begin
            step();
            steps++;
            if (gb_d_oe === lvl) ok = 1'b1;
        end
    endtask

    task automatic do_read(input string nm, input logic [15:0] a, input logic ncs, input logic claim);
        int   t;
        logic ok;
        rd_pulses = 0;
        gb_a   = a;
        gb_ncs = ncs;
        gb_nrd = 1'b0;
        wait_oe(1'b1, 20, t, ok);
        if (claim) begin
            check({nm, " oe_rise"}, ok, 1'b1);
            check({nm, " latency"}, t, SYNC + 2 + lat);
            check({nm, " data"}, gb_d_out, rom(a));
            check({nm, " rd_pulses"}, rd_pulses, 1);
            check({nm, " mem_addr"}, last_rd_addr, a);
            step();
            step();
            check({nm, " oe_hold"}, gb_d_oe, 1'b1);
        end else begin
            check({nm, " no_oe"}, ok, 1'b0);
            check({nm, " no_rd"}, rd_pulses, 0);
        end
        gb_nrd = 1'b1;
        repeat (SYNC) step();
        if (claim) check({nm, " oe_until_release"}, gb_d_oe, 1'b1);
        step();
        check({nm, " oe_off"}, gb_d_oe, 1'b0);
        repeat (4) step();
        gb_ncs = 1'b1;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d, input logic ncs);
        if (is_claimed(a, ncs)) begin
            if (q.size() < CAP) q.push_back({a, d});
            else model_ovf = 1'b1;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic ncs);
        gb_a    = a;
        gb_d_in = d;
        gb_ncs  = ncs;
        gb_nwr  = 1'b0;
        repeat (SYNC + 2) step();
        gb_nwr = 1'b1;
        repeat (SYNC + 2) step();
        gb_ncs = 1'b1;
    endtask

    task automatic drain(input string nm);
        logic [23:0] e;
        int          t;
        wr_ready = 1'b1;
        t = 0;
        while (t < 40) begin
            if (wr_valid) begin
                if (q.size() == 0) begin
                    check({nm, " extra_pop"}, wr_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    check({nm, " wr_addr"}, wr_addr, e[23:8]);
                    check({nm, " wr_data"}, wr_data, e[7:0]);
                end
            end else if (q.size() == 0) begin
                break;
            end
            step();
            t++;
        end
        wr_ready = 1'b0;
        check({nm, " missing_entries"}, q.size(), 0);
        check({nm, " empty"}, wr_valid, 1'b0);
    endtask

    read_vec_t rvec[9];

    initial begin : main
        int          t;
        logic        ok;
        logic        all_on;
        logic [15:0] ra;
        logic [7:0]  rd;
        logic        rn;
        int          n;
        int          sel;

        rvec[0] = '{16'h0150, 1'b1, 1'b1};
        rvec[1] = '{16'hA010, 1'b1, 1'b0};
        rvec[2] = '{16'hA010, 1'b0, 1'b1};
        rvec[3] = '{16'h7FFF, 1'b1, 1'b1};
        rvec[4] = '{16'h8000, 1'b0, 1'b0};
        rvec[5] = '{16'hC000, 1'b0, 1'b0};
        rvec[6] = '{16'hBFFF, 1'b0, 1'b1};
        rvec[7] = '{16'hFF00, 1'b0, 1'b0};
        rvec[8] = '{16'h0000, 1'b1, 1'b1};

        rst = 1'b1; gb_a = 16'h0000; gb_d_in = 8'h00;
        gb_nrd = 1'b1; gb_nwr = 1'b1; gb_ncs = 1'b1; wr_ready = 1'b0;
        model_ovf = 1'b0;
        repeat (4) step();
        check("reset gb_d_oe", gb_d_oe, 1'b0);
        check("reset gb_d_out", gb_d_out, 8'h00);
        check("reset mem_rd", mem_rd, 1'b0);
        check("reset mem_addr", mem_addr, 16'h0000);
        check("reset wr_valid", wr_valid, 1'b0);
        check("reset wr_addr", wr_addr, 16'h0000);
        check("reset wr_data", wr_data, 8'h00);
        check("reset overflow", overflow, 1'b0);
        rst = 1'b0;
        step();

        // Table-driven reads
        for (int i = 0; i < 9; i++) begin
            do_read($sformatf("read_vec%0d", i), rvec[i].addr, rvec[i].ncs, rvec[i].claim);
        end

        // Address step while /RD stays low: re-fetch and re-drive
        rd_pulses = 0;
        gb_a = 16'h4000; gb_nrd = 1'b0;
        wait_oe(1'b1, 20, t, ok);
        check("step first_oe", ok, 1'b1);
        check("step first_data", gb_d_out, rom(16'h4000));
        gb_a = 16'h4001;
        wait_oe(1'b0, 10, t, ok);
        check("step oe_drop", ok, 1'b1);
        wait_oe(1'b1, 20, t, ok);
        check("step second_oe", ok, 1'b1);
        check("step second_data", gb_d_out, rom(16'h4001));
        check("step rd_pulses", rd_pulses, 2);
        check("step mem_addr", last_rd_addr, 16'h4001);
        gb_nrd = 1'b1;
        repeat (6) step();

        // Valid in the same cycle as the fetch strobe is ignored
        lat = 0; rd_pulses = 0;
        gb_a = 16'h1234; gb_nrd = 1'b0;
        repeat (15) step();
        check("samecycle no_oe", gb_d_oe, 1'b0);
        check("samecycle rd_pulses", rd_pulses, 1);
        gb_nrd = 1'b1;
        repeat (6) step();

        // Abort during WAIT: late data must be discarded
        lat = 4;
        gb_a = 16'h2222; gb_nrd = 1'b0;
        repeat (SYNC + 1) step();
        gb_nrd = 1'b1;
        all_on = 1'b0;
        repeat (12) begin
            step();
            if (gb_d_oe) all_on = 1'b1;
        end
        check("abort no_oe", all_on, 1'b0);
        lat = 2;

        // Randomized reads
        for (int i = 0; i < 16; i++) begin
            ra  = 16'($urandom);
            rn  = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 4);
            do_read($sformatf("rand_read%0d", i), ra, rn, is_claimed(ra, rn));
        end
        lat = 2;

        // Five writes with no consumer
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            do_write(16'h2000, 8'(i), 1'b1);
            model_write(16'h2000, 8'(i), 1'b1);
        end
        check("five_writes overflow", overflow, 1'b1);
        check("five_writes valid", wr_valid, 1'b1);
        drain("five_writes");

        // Full buffer: write edge coincides with a pop
        do_reset();
        for (int i = 0; i < CAP; i++) begin
            do_write(16'h3000 + 16'(i), 8'h10 + 8'(i), 1'b1);
            model_write(16'h3000 + 16'(i), 8'h10 + 8'(i), 1'b1);
        end
        gb_a = 16'hA123; gb_d_in = 8'hAA; gb_ncs = 1'b0; gb_nwr = 1'b0;
        repeat (SYNC) step();
        check("pop_push head", wr_addr, q[0][23:8]);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        void'(q.pop_front());
        q.push_back({16'hA123, 8'hAA});
        gb_nwr = 1'b1;
        repeat (SYNC + 2) step();
        gb_ncs = 1'b1;
        check("pop_push overflow", overflow, 1'b0);
        drain("pop_push");

        // Write during DRIVE leaves the read untouched
        do_reset();
        gb_a = 16'h0150; gb_nrd = 1'b0;
        wait_oe(1'b1, 20, t, ok);
        check("rw drive", ok, 1'b1);
        gb_d_in = 8'h99; gb_nwr = 1'b0;
        all_on = 1'b1;
        repeat (SYNC + 2) begin
            step();
            if (!gb_d_oe) all_on = 1'b0;
        end
        gb_nwr = 1'b1;
        repeat (SYNC + 2) begin
            step();
            if (!gb_d_oe) all_on = 1'b0;
        end
        model_write(16'h0150, 8'h99, 1'b1);
        check("rw oe_steady", all_on, 1'b1);
        check("rw data_steady", gb_d_out, 8'h3E);
        gb_nrd = 1'b1;
        repeat (6) step();
        drain("rw");

        // Randomized write bursts against the queue model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                sel = $urandom_range(0, 2);
                rd  = 8'($urandom);
                if (sel == 0) begin
                    ra = {1'b0, 15'($urandom)}; rn = 1'($urandom_range(0, 1));
                end else if (sel == 1) begin
                    ra = {3'b101, 13'($urandom)}; rn = 1'b0;
                end else begin
                    ra = {3'b101, 13'($urandom)}; rn = 1'b1;
                end
                do_write(ra, rd, rn);
                model_write(ra, rd, rn);
            end
            check($sformatf("rand_wr%0d overflow", r), overflow, model_ovf);
            check($sformatf("rand_wr%0d valid", r), wr_valid, q.size() > 0);
            drain($sformatf("rand_wr%0d", r));
        end

        // Reset with the write strobe already low: no spurious event
        gb_a = 16'h1000; gb_d_in = 8'h77; gb_nwr = 1'b0;
        do_reset();
        repeat (10) step();
        check("rst_low_nwr no_event", wr_valid, 1'b0);
        gb_nwr = 1'b1;
        repeat (SYNC + 2) step();
        gb_nwr = 1'b0;
        repeat (SYNC + 2) step();
        gb_nwr = 1'b1;
        model_write(16'h1000, 8'h77, 1'b1);
        check("rst_low_nwr fresh_edge", wr_valid, 1'b1);
        drain("rst_low_nwr");

        // Reset during DRIVE
        gb_a = 16'h0150; gb_nrd = 1'b0;
        wait_oe(1'b1, 20, t, ok);
        check("rst_drive reached", ok, 1'b1);
        rst = 1'b1;
        step();
        check("rst_drive oe_edge", gb_d_oe, 1'b0);
        gb_nrd = 1'b1;
        step();
        check("rst_drive gb_d_out", gb_d_out, 8'h00);
        check("rst_drive mem_rd", mem_rd, 1'b0);
        check("rst_drive mem_addr", mem_addr, 16'h0000);
        check("rst_drive wr_valid", wr_valid, 1'b0);
        check("rst_drive wr_addr", wr_addr, 16'h0000);
        check("rst_drive wr_data", wr_data, 8'h00);
        check("rst_drive overflow", overflow, 1'b0);
        repeat (SYNC + 1) step();
        rst = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
